load_store_unit: RTL and testbench

Processor-side initiator for the word-wide data memory. It accepts one load or store request from the execute stage and converts RV32I byte, halfword and word accesses into word-addressed memory reads and writes. Sub-word stores use a read-modify-write sequence, because the memory only writes whole words. Load data is extracted from the right byte lanes, then sign- or zero-extended, before it is returned to writeback.

---
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: turns RV32I byte/half/word loads and stores into word-wide memory accesses.
// Latency (accept edge to resp_valid): error 1, load 2, SW 2, SB/SH 3 (read-modify-write).
// Backpressure: req_ready only in IDLE; requests offered while busy are ignored and must be held.
// Ports: clk/rst (sync, active-high); req_* request from execute (valid/ready handshake);
//        resp_* one-cycle completion with extended load data and error flag;
//        mem_* word-indexed memory port, mem_q combinational from mem_addr.
module load_store_unit #(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data,
   output logic        mem_we,
   input  logic [31:0] mem_q
);

   localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        lat_store;
   logic [2:0]  lat_f3;
   logic [31:0] lat_addr;
   logic [15:0] lat_wdata;   // only the sub-word part is needed after IDLE; SW data goes straight to mem_data_r
   logic [31:0] mem_data_r;

   logic        req_err;
   logic        req_is_sw;
   logic [7:0]  q_byte;
   logic [15:0] q_half;
   logic [31:0] load_val;
   logic [31:0] merged;

   // Classify the incoming request from the live request fields.
   always_comb begin
      req_err = 1'b0;
      case (req_funct3)
         3'b000:  req_err = 1'b0;
         3'b001:  req_err = req_addr[0];
         3'b010:  req_err = |req_addr[1:0];
         3'b100:  req_err = req_store;
         3'b101:  req_err = req_store | req_addr[0];
         default: req_err = 1'b1;
      endcase
      if (req_addr[31:2] >= WORD_LIMIT) begin
         req_err = 1'b1;
      end
   end

   assign req_is_sw = req_store && (req_funct3 == 3'b010);

   // Lane selection (little-endian) and extension of the read word.
   always_comb begin
      q_byte   = mem_q[8*lat_addr[1:0] +: 8];
      q_half   = lat_addr[1] ? mem_q[31:16] : mem_q[15:0];
      load_val = mem_q;
      case (lat_f3)
         3'b000:  load_val = {{24{q_byte[7]}}, q_byte};
         3'b100:  load_val = {24'h0, q_byte};
         3'b001:  load_val = {{16{q_half[15]}}, q_half};
         3'b101:  load_val = {16'h0, q_half};
         default: load_val = mem_q;
      endcase
   end

   // Sub-word store merge: the read word with the addressed lane replaced.
   always_comb begin
      merged = mem_q;
      if (lat_f3 == 3'b000) begin
         merged[8*lat_addr[1:0] +: 8] = lat_wdata[7:0];
      end else begin
         merged[16*lat_addr[1] +: 16] = lat_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err) begin
                  state_nxt = RESP;
               end else if (req_is_sw) begin
                  state_nxt = WRITE;
               end else begin
                  state_nxt = READ;   // loads, and SB/SH which must read first
               end
            end
         end
         READ:    state_nxt = lat_store ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_store  <= 1'b0;
         lat_f3     <= 3'b000;
         lat_addr   <= 32'h0;
         lat_wdata  <= 16'h0;
         mem_data_r <= 32'h0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_store  <= req_store;
                  lat_f3     <= req_funct3;
                  lat_addr   <= req_addr;
                  lat_wdata  <= req_wdata[15:0];
                  resp_rdata <= 32'h0;
                  resp_err   <= req_err;
                  if (!req_err && req_is_sw) begin
                     mem_data_r <= req_wdata;
                  end
               end
            end
            READ: begin
               if (lat_store) begin
                  mem_data_r <= merged;
               end else begin
                  resp_rdata <= load_val;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   // A reset landing on the WRITE cycle must not commit the write.
   assign mem_we     = (state == WRITE) && !rst;
   assign mem_addr   = ((state == READ) || (state == WRITE)) ? {2'b00, lat_addr[31:2]} : 32'h0;
   assign mem_data   = mem_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_we;
   logic [31:0] mem_q;

   int tests = 0;
   int fails = 0;

   // memory seen by the DUT, plus the reference copy
   logic [31:0] dmem    [256];
   logic [31:0] ref_mem [256];
   logic        pre_we;
   logic [7:0]  pre_idx;
   logic [31:0] pre_dat;

   int          we_cnt  = 0;
   int          acc_cnt = 0;
   logic [31:0] wr_addr = 32'h0;
   logic [31:0] wr_data = 32'h0;

   load_store_unit #(.MEM_WORDS(256)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_we     (mem_we),
      .mem_q      (mem_q)
   );

   always #5 clk = ~clk;

   assign mem_q = (mem_addr < 32'd256) ? dmem[mem_addr[7:0]] : 32'h0;

   always @(posedge clk) begin
      if (pre_we) begin
         dmem[pre_idx] <= pre_dat;
      end else if (mem_we) begin
         dmem[mem_addr[7:0]] <= mem_data;
      end
      if (mem_we) begin
         we_cnt  <= we_cnt + 1;
         wr_addr <= mem_addr;
         wr_data <= mem_data;
      end
      if (req_valid && req_ready && !rst) begin
         acc_cnt <= acc_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference behaviour of one request; updates ref_mem for successful stores.
   task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd,
                        output int e_lat, output int e_we);
      int unsigned idx;
      int unsigned off;
      logic [31:0] w;
      logic [31:0] b;
      logic [31:0] h;
      logic [31:0] mask;
      idx   = addr >> 2;
      off   = addr % 4;
      e_err = (f3 == 3) || (f3 == 6) || (f3 == 7) || (st && f3 >= 4) ||
              ((f3 == 1 || f3 == 5) && (off % 2 != 0)) || (f3 == 2 && off != 0) ||
              (idx >= 256);
      e_rd  = 32'h0;
      e_we  = 0;
      if (e_err) begin
         e_lat = 1;
      end else if (!st) begin
         e_lat = 2;
         w = ref_mem[idx];
         b = (w >> (8 * off)) & 32'hFF;
         h = (w >> (16 * (off / 2))) & 32'hFFFF;
         if (f3 == 0)      e_rd = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
         else if (f3 == 4) e_rd = b;
         else if (f3 == 1) e_rd = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
         else if (f3 == 5) e_rd = h;
         else              e_rd = w;
      end else begin
         e_we = 1;
         if (f3 == 2) begin
            e_lat = 2;
            ref_mem[idx] = wd;
         end else begin
            e_lat = 3;
            if (f3 == 0) begin
               mask = 32'hFF << (8 * off);
               ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd & 32'hFF) << (8 * off));
            end else begin
               mask = 32'hFFFF << (8 * off);
               ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd & 32'hFFFF) << (8 * off));
            end
         end
      end
   endtask

   // Issue one request and check everything about its completion.
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold);
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat;
      int          e_we;
      int          lat;
      int          we0;
      int          acc0;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_valid  = 1'b1;
      for (int i = 0; i < 20 && !req_ready; i++) begin
         @(posedge clk); #1;
      end
      check("ready_before_accept", {31'h0, req_ready}, 32'h1);
      we0  = we_cnt;
      acc0 = acc_cnt;
      model(st, f3, addr, wd, e_err, e_rd, e_lat, e_we);
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 10) begin
         check("ready_low_busy", {31'h0, req_ready}, 32'h0);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(e_lat));
      check("resp_err", {31'h0, resp_err}, {31'h0, e_err});
      check("resp_rdata", resp_rdata, e_rd);
      check("write_count", 32'(we_cnt - we0), 32'(e_we));
      check("accept_once", 32'(acc_cnt - acc0), 32'h1);
      if (e_we != 0) begin
         check("wr_addr", wr_addr, addr >> 2);
         check("wr_data", wr_data, ref_mem[addr >> 2]);
         check("mem_word", dmem[addr[9:2]], ref_mem[addr >> 2]);
      end
      @(posedge clk); #1;
      check("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int we0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      pre_we     = 1'b0;
      pre_idx    = 8'h0;
      pre_dat    = 32'h0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) begin
         pre_we  = 1'b1;
         pre_idx = 8'(i);
         pre_dat = (i == 4) ? 32'h8899AABB : ((i < 16) ? $urandom : 32'h0);
         ref_mem[i] = pre_dat;
         @(posedge clk); #1;
      end
      pre_we = 1'b0;
      check("rst_req_ready", {31'h0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_err", {31'h0, resp_err}, 32'h0);
      check("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_data", mem_data, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // directed loads on word 4 = 0x8899AABB
      do_req(1'b0, 3'b000, 32'h11, 32'h0, 1'b0);
      do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
      do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
      do_req(1'b0, 3'b101, 32'h10, 32'h0, 1'b0);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
      // sub-word store then readback (expects 0x8877AABB)
      do_req(1'b1, 3'b000, 32'h12, 32'h12345677, 1'b0);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
      check("sb_result", ref_mem[4], 32'h8877AABB);
      // error cases
      do_req(1'b1, 3'b001, 32'h11, 32'hCAFE, 1'b0);
      do_req(1'b0, 3'b010, 32'h16, 32'h0, 1'b0);
      do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
      do_req(1'b0, 3'b010, 32'h400, 32'h0, 1'b0);
      do_req(1'b1, 3'b100, 32'h10, 32'h0, 1'b0);

      // reset landing on the WRITE cycle of an SW
      req_store  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h20;
      req_wdata  = 32'hDEADBEEF;
      req_valid  = 1'b1;
      for (int i = 0; i < 20 && !req_ready; i++) begin
         @(posedge clk); #1;
      end
      we0 = we_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("sw_in_write", {31'h0, mem_we}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstw_no_write", 32'(we_cnt - we0), 32'h0);
      check("rstw_word8", dmem[8], ref_mem[8]);
      check("rstw_req_ready", {31'h0, req_ready}, 32'h1);
      check("rstw_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rstw_mem_addr", mem_addr, 32'h0);
      check("rstw_mem_data", mem_data, 32'h0);
      check("rstw_resp_rdata", resp_rdata, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // req_valid held high, alternating LW/SW
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) do_req(1'b0, 3'b010, 32'(4 * (k % 4)), 32'h0, 1'b1);
         else            do_req(1'b1, 3'b010, 32'(4 * (k % 4)), $urandom, 1'b1);
      end
      req_valid = 1'b0;
      @(posedge clk); #1;

      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) == 0) a = $urandom | 32'h400;
         else                           a = 32'($urandom_range(0, 63));
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0);
      end

      for (int i = 0; i < 16; i++) begin
         check("final_mem", dmem[i], ref_mem[i]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
